fpu_fwd_ctrl: RTL

Producer and control end of the FP operand-forwarding interface. It holds the FPU result pipeline registers for the MEM and WB stages and drives fpu_result_mem and fpu_result_wb. From the EX-stage source specifiers it generates the 2-bit forward_x/y/z selects, with encoding 00 = register file, 01 = WB, 10 = MEM. It also keeps a pending-write scoreboard for iterative FDIV/FSQRT results and raises a stall when a consumer reads a register that is not yet produced.

---
 rtl/fp_pkg.sv | 23 ++
 rtl/fpu_fwd_sel.sv | 31 +++
 rtl/fpu_fwd_ctrl.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/fp_pkg.sv
// fp_pkg: shared types and constants for the FP operand-forwarding control block.
//   FLEN       FP data width
//   NREG       number of FP registers
//   RAW        register address width
//   FWD_*      2-bit forward-select encodings driven to the operand muxes
//   stage_t    packed pipeline stage entry {valid, rd, data}
package fp_pkg;

  localparam int unsigned FLEN = 32;
  localparam int unsigned NREG = 32;
  localparam int unsigned RAW  = 5;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef struct packed {
    logic            valid;
    logic [RAW-1:0]  rd;
    logic [FLEN-1:0] data;
  } stage_t;

endpackage

// File: rtl/fpu_fwd_sel.sv
// fpu_fwd_sel: per-operand forward-select comparator.
//   i_use        operand is actually read
//   i_rs         operand source register
//   i_mem_valid  MEM stage holds a result
//   i_mem_rd     MEM stage destination
//   i_wb_valid   WB stage holds a result
//   i_wb_rd      WB stage destination
//   o_sel        FWD_MEM / FWD_WB / FWD_RF
module fpu_fwd_sel
  import fp_pkg::*;
(
  input  logic           i_use,
  input  logic [RAW-1:0] i_rs,
  input  logic           i_mem_valid,
  input  logic [RAW-1:0] i_mem_rd,
  input  logic           i_wb_valid,
  input  logic [RAW-1:0] i_wb_rd,
  output logic [1:0]     o_sel
);

  // MEM is younger than WB, so it wins when both hold the same register.
  always_comb begin
    o_sel = FWD_RF;
    if (i_use && i_mem_valid && (i_mem_rd == i_rs)) begin
      o_sel = FWD_MEM;
    end else if (i_use && i_wb_valid && (i_wb_rd == i_rs)) begin
      o_sel = FWD_WB;
    end
  end

endmodule

// File: rtl/fpu_fwd_ctrl.sv
// fpu_fwd_ctrl: FPU result pipeline (MEM/WB) plus forwarding and hazard control.
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_pipe_hold           freeze MEM/WB
//   i_ex_*                EX-stage single-cycle result / long-op issue
//   i_long_*              iterative unit (FDIV/FSQRT) completion
//   i_rs*_addr, i_use_rs* consumer source operands
//   o_forward_x/y/z       operand mux selects (00 RF, 01 WB, 10 MEM)
//   o_fpu_result_mem/wb   stage results
//   o_fp_rf_we/waddr/wdata register-file write port (from WB)
//   o_hazard_stall        combinational stall to the front end
module fpu_fwd_ctrl
  import fp_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_pipe_hold,
  input  logic            i_ex_valid,
  input  logic            i_ex_wen,
  input  logic [RAW-1:0]  i_ex_rd,
  input  logic [FLEN-1:0] i_ex_result,
  input  logic            i_ex_long_issue,
  input  logic            i_long_done,
  input  logic [RAW-1:0]  i_long_rd,
  input  logic [FLEN-1:0] i_long_result,
  input  logic [RAW-1:0]  i_rs1_addr,
  input  logic [RAW-1:0]  i_rs2_addr,
  input  logic [RAW-1:0]  i_rs3_addr,
  input  logic            i_use_rs1,
  input  logic            i_use_rs2,
  input  logic            i_use_rs3,
  output logic [1:0]      o_forward_x,
  output logic [1:0]      o_forward_y,
  output logic [1:0]      o_forward_z,
  output logic [FLEN-1:0] o_fpu_result_mem,
  output logic [FLEN-1:0] o_fpu_result_wb,
  output logic            o_fp_rf_we,
  output logic [RAW-1:0]  o_fp_rf_waddr,
  output logic [FLEN-1:0] o_fp_rf_wdata,
  output logic            o_hazard_stall
);

  stage_t          r_mem;
  stage_t          r_wb;
  stage_t          r_skid;
  logic [NREG-1:0] r_pending;

  stage_t          w_mem_d;
  logic [NREG-1:0] w_pending_d;
  logic            w_stall;
  logic            w_clr_en;
  logic [RAW-1:0]  w_clr_rd;
  logic            w_set_en;

  // A long result (live or skidded) owns MEM entry this cycle, so an EX write must retry.
  always_comb begin
    w_stall = (i_use_rs1 & r_pending[i_rs1_addr]) |
              (i_use_rs2 & r_pending[i_rs2_addr]) |
              (i_use_rs3 & r_pending[i_rs3_addr]) |
              ((i_long_done | r_skid.valid) & i_ex_valid & i_ex_wen);
  end

  always_comb begin
    w_mem_d  = '{valid: 1'b0, rd: r_mem.rd, data: r_mem.data};
    w_clr_en = 1'b0;
    w_clr_rd = i_long_rd;
    if (r_skid.valid) begin
      w_mem_d  = r_skid;
      w_clr_en = 1'b1;
      w_clr_rd = r_skid.rd;
    end else if (i_long_done) begin
      w_mem_d  = '{valid: 1'b1, rd: i_long_rd, data: i_long_result};
      w_clr_en = 1'b1;
    end else if (i_ex_valid && i_ex_wen && !w_stall) begin
      w_mem_d = '{valid: 1'b1, rd: i_ex_rd, data: i_ex_result};
    end
  end

  // Clear first, then set, so a same-register set/clear leaves the bit set.
  always_comb begin
    w_set_en    = i_ex_valid & i_ex_long_issue & ~w_stall;
    w_pending_d = r_pending;
    if (w_clr_en && !i_pipe_hold) begin
      w_pending_d[w_clr_rd] = 1'b0;
    end
    if (w_set_en) begin
      w_pending_d[i_ex_rd] = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mem     <= '0;
      r_wb      <= '0;
      r_skid    <= '0;
      r_pending <= '0;
    end else begin
      r_pending <= w_pending_d;
      if (!i_pipe_hold) begin
        r_mem        <= w_mem_d;
        r_wb         <= r_mem;
        r_skid.valid <= 1'b0;
      end else if (i_long_done && !r_skid.valid) begin
        // Park the pulse until the pipeline is released.
        r_skid <= '{valid: 1'b1, rd: i_long_rd, data: i_long_result};
      end
    end
  end

  fpu_fwd_sel u_sel_x (
    .i_use       (i_use_rs1),
    .i_rs        (i_rs1_addr),
    .i_mem_valid (r_mem.valid),
    .i_mem_rd    (r_mem.rd),
    .i_wb_valid  (r_wb.valid),
    .i_wb_rd     (r_wb.rd),
    .o_sel       (o_forward_x)
  );

  fpu_fwd_sel u_sel_y (
    .i_use       (i_use_rs2),
    .i_rs        (i_rs2_addr),
    .i_mem_valid (r_mem.valid),
    .i_mem_rd    (r_mem.rd),
    .i_wb_valid  (r_wb.valid),
    .i_wb_rd     (r_wb.rd),
    .o_sel       (o_forward_y)
  );

  fpu_fwd_sel u_sel_z (
    .i_use       (i_use_rs3),
    .i_rs        (i_rs3_addr),
    .i_mem_valid (r_mem.valid),
    .i_mem_rd    (r_mem.rd),
    .i_wb_valid  (r_wb.valid),
    .i_wb_rd     (r_wb.rd),
    .o_sel       (o_forward_z)
  );

  assign o_fpu_result_mem = r_mem.data;
  assign o_fpu_result_wb  = r_wb.data;
  assign o_fp_rf_we       = r_wb.valid;
  assign o_fp_rf_waddr    = r_wb.rd;
  assign o_fp_rf_wdata    = r_wb.data;
  assign o_hazard_stall   = w_stall;

endmodule
